// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit and its target calculator.
package pc_pkg;

  typedef enum logic {BRANCH_IMM = 1'b0, RESULT = 1'b1} redirect_sel_e;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2} pc_state_e;

  localparam int IMM_W = 24;
  localparam int MAX_W = 64;

  // Sign-extends a 24-bit word offset, converts it to a byte offset and keeps the low width bits.
  function automatic logic [MAX_W-1:0] sext_imm24_shl2(input logic [IMM_W-1:0] imm,
                                                        input int width);
    logic [MAX_W-1:0] ext;
    logic [MAX_W-1:0] mask;
    ext  = {{(MAX_W-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
    mask = (width >= MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    return ext & mask;
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target: PC-relative branch or word-aligned absolute target.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int PC_AHEAD = 8
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              redirect_sel,
  input  logic [23:0]       branch_imm24,
  input  logic [ADDR_W-1:0] result_target,
  output logic [ADDR_W-1:0] target
);

  logic signed [ADDR_W-1:0] imm_off;
  logic        [ADDR_W-1:0] branch_target;
  logic        [ADDR_W-1:0] result_aligned;

  assign imm_off        = ADDR_W'(sext_imm24_shl2(branch_imm24, ADDR_W));
  assign branch_target  = pc + ADDR_W'(PC_AHEAD) + $unsigned(imm_off);
  assign result_aligned = result_target & ~ADDR_W'(3);

  always_comb begin
    target = branch_target;
    if (redirect_sel_e'(redirect_sel) == RESULT) target = result_aligned;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with fetch handshake, stall and a pending-redirect latch so that
// redirects arriving while fetch is blocked are applied once the stall clears.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = 4,
  parameter int              PC_AHEAD     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              fetch_ready,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_step,
  output logic [ADDR_W-1:0] pc_ahead,
  input  logic              redirect_valid,
  input  logic              redirect_sel,
  input  logic [23:0]       branch_imm24,
  input  logic [ADDR_W-1:0] result_target,
  output logic              redirect_pending
);

  pc_state_e         state;
  pc_state_e         state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pending;
  logic [ADDR_W-1:0] pending_next;
  logic [ADDR_W-1:0] target;
  logic              advance;
  logic              blocked;

  assign pc_plus_step = pc + ADDR_W'(STEP);
  assign pc_ahead     = pc + ADDR_W'(PC_AHEAD);
  assign advance      = fetch_valid & fetch_ready & ~stall;
  assign blocked      = stall | (fetch_valid & ~fetch_ready);

  // Branch base is always the registered pc, including while a redirect is held.
  pc_target_calc #(
    .ADDR_W   (ADDR_W),
    .PC_AHEAD (PC_AHEAD)
  ) u_target (
    .pc            (pc),
    .redirect_sel  (redirect_sel),
    .branch_imm24  (branch_imm24),
    .result_target (result_target),
    .target        (target)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= BOOT;
      pc      <= RESET_VECTOR;
      pending <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending;
    unique case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (redirect_valid && !blocked) begin
          pc_next = target;
        end else if (redirect_valid) begin
          pending_next = target;
          state_next   = HOLD;
        end else if (advance) begin
          pc_next = pc_plus_step;
        end
      end
      HOLD: begin
        // A redirect arriving on the release edge is newer than the latched one.
        if (!stall) begin
          pc_next    = redirect_valid ? target : pending;
          state_next = RUN;
        end else if (redirect_valid) begin
          pending_next = target;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    fetch_valid      = (state == RUN);
    redirect_pending = (state == HOLD);
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scenario bench for pc_unit: expected pc/fetch_valid/redirect_pending queued per cycle.
module tb_pc_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        rp;
  } exp_t;

  typedef struct packed {
    logic        rv;
    logic        sel;
    logic [23:0] imm;
    logic [31:0] res;
    logic        stl;
    logic        rdy;
    logic [31:0] epc;
    logic        efv;
    logic        erp;
  } stim_t;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus_step;
  logic [31:0] pc_ahead;
  logic        redirect_valid;
  logic        redirect_sel;
  logic [23:0] branch_imm24;
  logic [31:0] result_target;
  logic        redirect_pending;

  int   checks;
  int   failures;
  exp_t sb[$];

  pc_unit #(
    .ADDR_W       (32),
    .RESET_VECTOR (32'h0000_0000),
    .STEP         (4),
    .PC_AHEAD     (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .fetch_ready      (fetch_ready),
    .fetch_valid      (fetch_valid),
    .pc               (pc),
    .pc_plus_step     (pc_plus_step),
    .pc_ahead         (pc_ahead),
    .redirect_valid   (redirect_valid),
    .redirect_sel     (redirect_sel),
    .branch_imm24     (branch_imm24),
    .result_target    (result_target),
    .redirect_pending (redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic stim_t s(input logic rv, input logic sel, input logic [23:0] imm,
                              input logic [31:0] res, input logic stl, input logic rdy,
                              input logic [31:0] epc, input logic efv, input logic erp);
    stim_t t;
    t = '{rv, sel, imm, res, stl, rdy, epc, efv, erp};
    return t;
  endfunction

  // Drives one cycle of stimulus, queues its expectation and steps past the edge.
  task automatic run_step(input stim_t t);
    redirect_valid = t.rv;
    redirect_sel   = t.sel;
    branch_imm24   = t.imm;
    result_target  = t.res;
    stall          = t.stl;
    fetch_ready    = t.rdy;
    sb.push_back('{t.epc, t.efv, t.erp});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t  e;
    stim_t tbl [0:3];
    reset = 1'b1;
    redirect_valid = 1'b0; redirect_sel = 1'b0; branch_imm24 = '0; result_target = '0;
    stall = 1'b0; fetch_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back('{32'h0, 1'b0, 1'b0});
    e = sb.pop_front(); checks++;
    if (pc !== e.pc || fetch_valid !== e.fv || redirect_pending !== e.rp) begin
      failures++;
      $display("FAIL reset_held pc=%h fv=%b rp=%b required pc=%h fv=%b rp=%b",
               pc, fetch_valid, redirect_pending, e.pc, e.fv, e.rp);
    end
    reset = 1'b0;
    #1;
    sb.push_back('{32'h0, 1'b0, 1'b0});
    e = sb.pop_front(); checks++;
    if (pc !== e.pc || fetch_valid !== e.fv || redirect_pending !== e.rp) begin
      failures++;
      $display("FAIL boot_bubble pc=%h fv=%b rp=%b required pc=%h fv=%b rp=%b",
               pc, fetch_valid, redirect_pending, e.pc, e.fv, e.rp);
    end
    tbl[0] = s(0, 0, 24'h0, 32'h0, 0, 1, 32'h0, 1, 0);
    tbl[1] = s(0, 0, 24'h0, 32'h0, 0, 1, 32'h4, 1, 0);
    tbl[2] = s(0, 0, 24'h0, 32'h0, 0, 1, 32'h8, 1, 0);
    tbl[3] = s(0, 0, 24'h0, 32'h0, 0, 1, 32'hC, 1, 0);
    for (int i = 0; i < 4; i++) begin
      run_step(tbl[i]);
      e = sb.pop_front(); checks++;
      if (pc !== e.pc || fetch_valid !== e.fv || redirect_pending !== e.rp) begin
        failures++;
        $display("FAIL sequential[%0d] pc=%h fv=%b rp=%b required pc=%h fv=%b rp=%b",
                 i, pc, fetch_valid, redirect_pending, e.pc, e.fv, e.rp);
      end
    end
    checks++;
    if (pc_plus_step !== 32'h10 || pc_ahead !== 32'h14) begin
      failures++;
      $display("FAIL comb_outputs plus_step=%h ahead=%h required plus_step=%h ahead=%h",
               pc_plus_step, pc_ahead, 32'h10, 32'h14);
    end
  endtask

  task automatic test_branch();
    exp_t  e;
    stim_t tbl [0:4];
    tbl[0] = s(1, 1, 24'h0,      32'h0000_0100, 0, 1, 32'h100,  1, 0);
    tbl[1] = s(1, 0, 24'hFFFFFE, 32'h0,         0, 1, 32'h100,  1, 0);
    tbl[2] = s(1, 0, 24'h000003, 32'h0,         0, 1, 32'h114,  1, 0);
    tbl[3] = s(1, 1, 24'h0,      32'h0000_2003, 0, 1, 32'h2000, 1, 0);
    tbl[4] = s(0, 0, 24'h0,      32'h0,         0, 1, 32'h2004, 1, 0);
    for (int i = 0; i < 5; i++) begin
      run_step(tbl[i]);
      e = sb.pop_front(); checks++;
      if (pc !== e.pc || fetch_valid !== e.fv || redirect_pending !== e.rp) begin
        failures++;
        $display("FAIL branch[%0d] pc=%h fv=%b rp=%b required pc=%h fv=%b rp=%b",
                 i, pc, fetch_valid, redirect_pending, e.pc, e.fv, e.rp);
      end
    end
  endtask

  task automatic test_stall_redirect();
    exp_t  e;
    stim_t tbl [0:13];
    tbl[0]  = s(1, 1, 24'h0,      32'h040, 0, 1, 32'h040, 1, 0);
    tbl[1]  = s(1, 1, 24'h0,      32'h800, 1, 1, 32'h040, 0, 1);
    tbl[2]  = s(1, 1, 24'h0,      32'h900, 1, 1, 32'h040, 0, 1);
    tbl[3]  = s(0, 0, 24'h0,      32'h0,   1, 1, 32'h040, 0, 1);
    tbl[4]  = s(0, 0, 24'h0,      32'h0,   0, 1, 32'h900, 1, 0);
    tbl[5]  = s(1, 1, 24'h0,      32'h700, 1, 1, 32'h900, 0, 1);
    tbl[6]  = s(1, 1, 24'h0,      32'hA00, 0, 1, 32'hA00, 1, 0);
    tbl[7]  = s(1, 0, 24'h000001, 32'h0,   1, 1, 32'hA00, 0, 1);
    tbl[8]  = s(0, 0, 24'h0,      32'h0,   0, 1, 32'hA0C, 1, 0);
    tbl[9]  = s(1, 1, 24'h0,      32'h300, 0, 0, 32'hA0C, 0, 1);
    tbl[10] = s(0, 0, 24'h0,      32'h0,   0, 0, 32'h300, 1, 0);
    tbl[11] = s(0, 0, 24'h0,      32'h0,   0, 1, 32'h304, 1, 0);
    tbl[12] = s(0, 0, 24'h0,      32'h0,   1, 1, 32'h304, 1, 0);
    tbl[13] = s(0, 0, 24'h0,      32'h0,   0, 1, 32'h308, 1, 0);
    for (int i = 0; i < 14; i++) begin
      run_step(tbl[i]);
      e = sb.pop_front(); checks++;
      if (pc !== e.pc || fetch_valid !== e.fv || redirect_pending !== e.rp) begin
        failures++;
        $display("FAIL stall_redirect[%0d] pc=%h fv=%b rp=%b required pc=%h fv=%b rp=%b",
                 i, pc, fetch_valid, redirect_pending, e.pc, e.fv, e.rp);
      end
    end
  endtask

  task automatic test_fetch_ready();
    exp_t  e;
    stim_t tbl [0:4];
    tbl[0] = s(1, 1, 24'h0, 32'h20, 0, 1, 32'h20, 1, 0);
    tbl[1] = s(0, 0, 24'h0, 32'h0,  0, 0, 32'h20, 1, 0);
    tbl[2] = s(0, 0, 24'h0, 32'h0,  0, 0, 32'h20, 1, 0);
    tbl[3] = s(0, 0, 24'h0, 32'h0,  0, 0, 32'h20, 1, 0);
    tbl[4] = s(0, 0, 24'h0, 32'h0,  0, 1, 32'h24, 1, 0);
    for (int i = 0; i < 5; i++) begin
      run_step(tbl[i]);
      e = sb.pop_front(); checks++;
      if (pc !== e.pc || fetch_valid !== e.fv || redirect_pending !== e.rp) begin
        failures++;
        $display("FAIL fetch_ready[%0d] pc=%h fv=%b rp=%b required pc=%h fv=%b rp=%b",
                 i, pc, fetch_valid, redirect_pending, e.pc, e.fv, e.rp);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t  e;
    stim_t tbl [0:2];
    tbl[0] = s(1, 1, 24'h0, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 1, 0);
    tbl[1] = s(0, 0, 24'h0, 32'h0,         0, 1, 32'h0,         1, 0);
    tbl[2] = s(0, 0, 24'h0, 32'h0,         0, 1, 32'h4,         1, 0);
    for (int i = 0; i < 3; i++) begin
      run_step(tbl[i]);
      e = sb.pop_front(); checks++;
      if (pc !== e.pc || fetch_valid !== e.fv || redirect_pending !== e.rp) begin
        failures++;
        $display("FAIL wrap[%0d] pc=%h fv=%b rp=%b required pc=%h fv=%b rp=%b",
                 i, pc, fetch_valid, redirect_pending, e.pc, e.fv, e.rp);
      end
    end
  endtask

  task automatic test_reset_in_hold();
    exp_t  e;
    stim_t tbl [0:1];
    run_step(s(1, 1, 24'h0, 32'h500, 1, 1, 32'h4, 0, 1));
    e = sb.pop_front(); checks++;
    if (pc !== e.pc || fetch_valid !== e.fv || redirect_pending !== e.rp) begin
      failures++;
      $display("FAIL hold_entry pc=%h fv=%b rp=%b required pc=%h fv=%b rp=%b",
               pc, fetch_valid, redirect_pending, e.pc, e.fv, e.rp);
    end
    reset = 1'b1;
    #1;
    sb.push_back('{32'h0, 1'b0, 1'b0});
    e = sb.pop_front(); checks++;
    if (pc !== e.pc || fetch_valid !== e.fv || redirect_pending !== e.rp) begin
      failures++;
      $display("FAIL async_reset pc=%h fv=%b rp=%b required pc=%h fv=%b rp=%b",
               pc, fetch_valid, redirect_pending, e.pc, e.fv, e.rp);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    tbl[0] = s(0, 0, 24'h0, 32'h0, 0, 1, 32'h0, 1, 0);
    tbl[1] = s(0, 0, 24'h0, 32'h0, 0, 1, 32'h4, 1, 0);
    for (int i = 0; i < 2; i++) begin
      run_step(tbl[i]);
      e = sb.pop_front(); checks++;
      if (pc !== e.pc || fetch_valid !== e.fv || redirect_pending !== e.rp) begin
        failures++;
        $display("FAIL post_reset[%0d] pc=%h fv=%b rp=%b required pc=%h fv=%b rp=%b",
                 i, pc, fetch_valid, redirect_pending, e.pc, e.fv, e.rp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_branch();
    test_stall_redirect();
    test_fetch_ready();
    test_wrap();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit; the next generation of the single-cycle next-PC mux.
- Owns the PC register and selects among sequential (PC+STEP), PC-relative branch (PC+PC_AHEAD+imm24<<2) and absolute load (result/readData) targets.
- Adds a fetch handshake, a stall input and a pending-redirect latch, so redirects that arrive while fetch is stalled are not lost.
- Sits between the control unit/datapath result bus and instruction memory.

Parameters:
- ADDR_W, 32, PC and target width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- STEP, 4, sequential increment in bytes.
- PC_AHEAD, 8, offset added to PC for R15 reads and branch base.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline hold request from the datapath.
- fetch_ready  in  1  instruction memory accepts the address this cycle.
- fetch_valid  out  1  pc is a valid fetch address.
- pc  out  ADDR_W  current fetch address (registered).
- pc_plus_step  out  ADDR_W  pc+STEP (combinational).
- pc_ahead  out  ADDR_W  pc+PC_AHEAD, used as the R15 read value (combinational).
- redirect_valid  in  1  redirect request this cycle.
- redirect_sel  in  1  redirect source: 0 = BRANCH_IMM, 1 = RESULT (absolute).
- branch_imm24  in  24  signed word offset for BRANCH_IMM.
- result_target  in  ADDR_W  absolute target for RESULT (readData/ALU).
- redirect_pending  out  1  a latched redirect is awaiting application.

Behaviour:
- Reset (asynchronous):
  - pc=RESET_VECTOR, state=BOOT, fetch_valid=0.
  - pending register=0, redirect_pending=0.
- States:
  - BOOT: fetch_valid=0; goes to RUN unconditionally on the next edge. This gives one bubble after reset release.
  - RUN: fetch_valid=1.
  - HOLD: fetch_valid=0; entered when a redirect is latched while blocked.
- Definitions:
  - advance = fetch_valid & fetch_ready & !stall.
  - blocked = stall | (fetch_valid & !fetch_ready).
- Target computation (combinational, all arithmetic modulo 2^ADDR_W):
  - BRANCH_IMM: pc + PC_AHEAD + (sign_extend(branch_imm24) << 2).
  - RESULT: result_target with bits [1:0] forced to 0.
- Priority each cycle in RUN: redirect > hold > sequential.
  - redirect_valid & !blocked: pc <= target next edge; stay RUN. Latency is 1 cycle.
  - redirect_valid & blocked: pending <= target; redirect_pending <= 1; go to HOLD. pc is unchanged.
  - no redirect & advance: pc <= pc+STEP.
  - no redirect & !advance: pc holds.
- In HOLD:
  - A new redirect_valid overwrites pending (newest wins). The BRANCH_IMM base is still the held pc.
  - When !stall: pc <= pending; redirect_pending <= 0; go to RUN. fetch_ready is ignored in HOLD.
- Wrap-around: pc = 2^ADDR_W - STEP advancing gives 0. No fault is raised.
- Reset mid-HOLD: pending is discarded; pc=RESET_VECTOR.
- Simultaneous redirect_valid and stall deassertion in HOLD: the new target wins and is applied directly that edge.
- Outputs pc, fetch_valid and redirect_pending are registered or state-decoded only. pc_plus_step and pc_ahead are combinational from pc.

Decomposition:
- Package pc_pkg holds:
  - typedef enum logic {BRANCH_IMM, RESULT} redirect_sel_e.
  - typedef enum logic [1:0] {BOOT, RUN, HOLD} pc_state_e.
  - Function sext_imm24_shl2(imm, width).
- One sub-module is natural: pc_target_calc, purely combinational. It takes pc, redirect_sel, branch_imm24 and result_target, and produces the aligned target. It is reused by the future branch predictor.
- The state machine, PC register and pending register stay in pc_unit.

Test Plan:
- Reset, then release with fetch_ready=1 and stall=0:
  - Cycle 1 after release: fetch_valid=0, pc=0.
  - Then pc steps 0, 4, 8, 12 with fetch_valid=1.
- At pc=0x100, BRANCH_IMM with imm24=0xFFFFFE (-2):
  - Next pc = 0x100 + 8 - 8 = 0x100.
  - With imm24=3: next pc = 0x114.
- RESULT redirect with result_target=0x0000_2003, unblocked:
  - Next pc = 0x2000 (low bits masked).
- Redirect during stall:
  - At pc=0x40 with stall=1, redirect RESULT 0x800 → redirect_pending=1, fetch_valid=0, pc stays 0x40.
  - A second redirect RESULT 0x900 in the next cycle overwrites pending.
  - Drop stall → pc=0x900, redirect_pending=0, fetch_valid=1.
- fetch_ready=0 for 3 cycles at pc=0x20, no redirect → pc holds 0x20, fetch_valid stays 1; resumes at 0x24 after ready.
- Wrap and mid-hold reset:
  - Force pc=0xFFFF_FFFC and advance → pc=0x0.
  - Assert reset while in HOLD → pc=RESET_VECTOR and redirect_pending=0 immediately, without waiting for a clock edge.
